// File: rtl/fifo_rd_ctrl_if.sv
// Bundle of signals that runs between the FIFO memory's read port, its
// snooped write handshake and the downstream valid/ready consumer.
// master: the read controller. slave: the memory/consumer side.
// Optional macro FIFO_RD_ERR_CNT_EN adds the 8-bit err_cnt signal.
interface fifo_rd_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    logic             mem_wr_en;
    logic             wr_full_err;
    logic             mem_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             rd_empty_err;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] mem_count;
    logic             rd_err;
    logic             clr_err;
`ifdef FIFO_RD_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    modport master (
`ifdef FIFO_RD_ERR_CNT_EN
        output err_cnt,
`endif
        output mem_rd_en, out_data, out_valid, mem_count, rd_err,
        input  mem_wr_en, wr_full_err, fifo_rd_data, rd_empty_err,
        input  out_ready, clr_err
    );

    modport slave (
`ifdef FIFO_RD_ERR_CNT_EN
        input  err_cnt,
`endif
        input  mem_rd_en, out_data, out_valid, mem_count, rd_err,
        output mem_wr_en, wr_full_err, fifo_rd_data, rd_empty_err,
        output out_ready, clr_err
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the FIFO memory. Keeps a mirror of the memory
// occupancy from the snooped write handshake and its own reads, issues reads
// only when the mirror is non-zero and the two-entry skid buffer has room,
// and presents the buffer head as a valid/ready stream.
// Optional macro FIFO_RD_ERR_CNT_EN adds a saturating 8-bit error counter.
module fifo_rd_ctrl #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    fifo_rd_ctrl_if.master bus
);
    // Skid buffer occupancy states
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [1:0]       buf_cnt;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [CNT_W-1:0] mem_count_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rd_err_q;
    logic             rd_issue;
    logic             wr_acc;
    logic             rd_acc;
    logic             empty_ev;
    logic             ovf_ev;
    logic             out_fire;

    // Reads depend only on registered state, never on out_ready
    assign rd_issue = (mem_count_q != '0) && (buf_cnt != TWO);
    assign wr_acc   = bus.mem_wr_en && !bus.wr_full_err;
    assign rd_acc   = rd_issue && !bus.rd_empty_err;
    assign empty_ev = rd_issue && bus.rd_empty_err;
    assign ovf_ev   = wr_acc && (mem_count_q == DEPTH_C);
    assign out_fire = (buf_cnt != EMPTY) && bus.out_ready;

    assign bus.mem_rd_en = rd_issue;
    assign bus.out_valid = (buf_cnt != EMPTY);
    assign bus.out_data  = slot0;
    assign bus.mem_count = mem_count_q;
    assign bus.rd_err    = rd_err_q;

    // Next mirror count: resync to 0 on an empty error, else +/-1 with saturation
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_nxt unassigned (no latch).
        cnt_nxt = mem_count_q;
        if (empty_ev) begin
            cnt_nxt = '0;
        end else if (wr_acc && !rd_acc && (mem_count_q != DEPTH_C)) begin
            cnt_nxt = mem_count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc && (mem_count_q != '0)) begin
            cnt_nxt = mem_count_q - CNT_W'(1);
        end
    end

    // Register the mirror count
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (!nRST) begin
            mem_count_q <= '0;
        end else begin
            mem_count_q <= cnt_nxt;
        end
    end

    // Skid buffer FSM: load on accepted reads, shift on consumer transfers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: data slots are reset because out_data is required to read 0 after reset.
            buf_cnt <= EMPTY;
            slot0   <= '0;
            slot1   <= '0;
        end else begin
            case (buf_cnt)
                EMPTY: begin
                    if (rd_acc) begin
                        slot0   <= bus.fifo_rd_data;
                        buf_cnt <= ONE;
                    end
                end
                ONE: begin
                    if (rd_acc && !out_fire) begin
                        slot1   <= bus.fifo_rd_data;
                        buf_cnt <= TWO;
                    end else if (out_fire && !rd_acc) begin
                        buf_cnt <= EMPTY;
                    end else if (out_fire && rd_acc) begin
                        slot0   <= bus.fifo_rd_data;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        slot0   <= slot1;
                        buf_cnt <= ONE;
                    end
                end
                default: buf_cnt <= EMPTY;
            endcase
        end
    end

    // Sticky error flag: a new error wins over a simultaneous clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_err_q <= 1'b0;
        end else if (empty_ev || ovf_ev) begin
            rd_err_q <= 1'b1;
        end else if (bus.clr_err) begin
            rd_err_q <= 1'b0;
        end
    end

`ifdef FIFO_RD_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [1:0] ev_n;
    logic [8:0] ecnt_sum;

    assign ev_n        = {1'b0, empty_ev} + {1'b0, ovf_ev};
    assign ecnt_sum    = {1'b0, err_cnt_q} + {7'b0, ev_n};
    assign bus.err_cnt = err_cnt_q;

    // Error event counter: saturates at 255, clear loses to a coincident event
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_cnt_q <= '0;
        end else if (bus.clr_err) begin
            if (ev_n == 2'd0) begin
                err_cnt_q <= '0;
            end
        end else if (ev_n != 2'd0) begin
            err_cnt_q <= ecnt_sum[8] ? 8'hFF : ecnt_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a queue-based memory model feeds the read port, a
// transaction-level reference model predicts occupancy, buffer fill and
// error state, and a monitor checks every consumer transfer against the
// order in which words were stored.
module tb_fifo_rd_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic CLK = 1'b0;
    logic nRST;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) bus ();

    fifo_rd_ctrl #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fire  = 0;
    bit mon_en  = 1'b0;

    logic [WIDTH-1:0] mem_q[$];   // contents of the modelled memory
    logic [WIDTH-1:0] exp_q[$];   // scoreboard: words in expected output order

    int m_cnt;    // reference mirror count
    int m_buf;    // reference words held in the skid buffer
    bit m_err;
    int m_ecnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.mem_wr_en    = 1'b0;
        bus.wr_full_err  = 1'b0;
        bus.rd_empty_err = 1'b1;
        bus.fifo_rd_data = '0;
        bus.out_ready    = 1'b0;
        bus.clr_err      = 1'b0;
    endtask

    task automatic clear_model();
        mem_q.delete();
        exp_q.delete();
        m_cnt  = 0;
        m_buf  = 0;
        m_err  = 1'b0;
        m_ecnt = 0;
    endtask

    // Holds reset across one rising edge; returns at posedge+1 with reset released
    task automatic apply_reset();
        mon_en = 1'b0;
        nRST   = 1'b0;
        drive_idle();
        clear_model();
        @(posedge CLK);
        #1;
        nRST   = 1'b1;
        mon_en = 1'b1;
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input bit we, input logic [WIDTH-1:0] d, input bit rdy,
                        input bit clr, input bit fe, input bit lie);
        bit full, empty, m_rd, m_fire, wacc, racc, eev, oev, d_rd;
        int nev;
        full  = (mem_q.size() >= DEPTH) && !lie;
        empty = fe || (mem_q.size() == 0);
        bus.mem_wr_en    = we;
        bus.wr_full_err  = full;
        bus.rd_empty_err = empty;
        bus.fifo_rd_data = (mem_q.size() != 0) ? mem_q[0] : '0;
        bus.out_ready    = rdy;
        bus.clr_err      = clr;
        m_rd   = (m_cnt != 0) && (m_buf < 2);
        m_fire = (m_buf != 0) && rdy;
        @(negedge CLK);
        d_rd = bus.mem_rd_en;
        @(posedge CLK);
        #1;
        // memory environment reacts to what the DUT actually requested
        if (d_rd && !empty) void'(mem_q.pop_front());
        if (we && !full && !lie) begin
            mem_q.push_back(d);
            exp_q.push_back(d);
        end
        // reference model
        wacc = we && !full;
        racc = m_rd && !empty;
        eev  = m_rd && empty;
        oev  = wacc && (m_cnt == DEPTH);
        if (eev) begin
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + int'(wacc) - int'(racc);
            if (m_cnt > DEPTH) m_cnt = DEPTH;
            if (m_cnt < 0) m_cnt = 0;
        end
        m_buf = m_buf - int'(m_fire) + int'(racc);
        if (eev || oev) m_err = 1'b1;
        else if (clr)   m_err = 1'b0;
        nev = int'(eev) + int'(oev);
        if (clr) begin
            if (nev == 0) m_ecnt = 0;
        end else begin
            m_ecnt = (m_ecnt + nev > 255) ? 255 : m_ecnt + nev;
        end
    endtask

    // Monitor: per-cycle state against the model, transfers against the scoreboard
    always @(negedge CLK) begin
        if (mon_en) begin
            check("mem_count", bus.mem_count, m_cnt);
            check("mem_rd_en", bus.mem_rd_en, (m_cnt != 0) && (m_buf < 2));
            check("out_valid", bus.out_valid, m_buf != 0);
            check("rd_err", bus.rd_err, m_err);
`ifdef FIFO_RD_ERR_CNT_EN
            check("err_cnt", bus.err_cnt, m_ecnt);
`endif
            if (bus.out_valid && bus.out_ready) begin
                n_fire++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_data: got %h with no word expected at %0t", bus.out_data, $time);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int fires0;
        nRST = 1'b0;
        drive_idle();
        clear_model();
        @(posedge CLK);
        #1;
        check("rst_mem_rd_en", bus.mem_rd_en, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_mem_count", bus.mem_count, 0);
        check("rst_rd_err", bus.rd_err, 0);
`ifdef FIFO_RD_ERR_CNT_EN
        check("rst_err_cnt", bus.err_cnt, 0);
`endif
        nRST   = 1'b1;
        mon_en = 1'b1;

        // single word, consumer always ready
        step(1, 32'hDEADBEEF, 1, 0, 0, 0);
        check("single_cnt1", bus.mem_count, 1);
        check("single_rd_en", bus.mem_rd_en, 1);
        step(0, 0, 1, 0, 0, 0);
        check("single_valid", bus.out_valid, 1);
        check("single_data", bus.out_data, 32'hDEADBEEF);
        check("single_cnt0", bus.mem_count, 0);
        check("single_rd_off", bus.mem_rd_en, 0);
        repeat (2) step(0, 0, 1, 0, 0, 0);

        // backpressure: eight words with the consumer stalled, then drain
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("bp_count", bus.mem_count, 6);
        check("bp_rd_en", bus.mem_rd_en, 0);
        check("bp_head", bus.out_data, 0);
        fires0 = n_fire;
        repeat (8) step(0, 0, 1, 0, 0, 0);
        check("bp_no_gaps", n_fire - fires0, 8);
        check("bp_drained", exp_q.size(), 0);

        // simultaneous accepted write and read at mem_count 3
        apply_reset();
        for (int i = 0; i < 5; i++) step(1, 32'h100 + i, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("sim_pre_cnt", bus.mem_count, 3);
        check("sim_pre_rd", bus.mem_rd_en, 1);
        step(1, 32'h105, 0, 0, 0, 0);
        check("sim_cnt", bus.mem_count, 3);
        repeat (12) step(0, 0, 1, 0, 0, 0);

        // asynchronous reset with the skid buffer full
        for (int i = 0; i < 8; i++) step(1, 32'h200 + i, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        mon_en = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_mem_count", bus.mem_count, 0);
        check("arst_mem_rd_en", bus.mem_rd_en, 0);
        apply_reset();

        // empty error while one word sits in the buffer
        step(1, 32'hA1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'hA2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("eerr_rd_err", bus.rd_err, 1);
        check("eerr_count", bus.mem_count, 0);
        check("eerr_valid", bus.out_valid, 1);
        step(0, 0, 0, 1, 0, 0);
        check("eerr_clr", bus.rd_err, 0);
`ifdef FIFO_RD_ERR_CNT_EN
        check("eerr_cnt", bus.err_cnt, 1);
`endif

        // 300 error events: writes the memory silently drops, each read then faults
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, i, 1, 0, 0, 1);
            step(0, 0, 1, 0, 0, 0);
        end
        check("sat_rd_err", bus.rd_err, 1);
`ifdef FIFO_RD_ERR_CNT_EN
        check("sat_err_cnt", bus.err_cnt, 255);
`endif
        step(0, 0, 1, 1, 0, 0);
        check("sat_clr", bus.rd_err, 0);

        // randomized traffic, occasional forced errors, lost writes and clears
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(1, 0) == 1, $urandom, $urandom_range(2, 0) != 0,
                 $urandom_range(15, 0) == 0, $urandom_range(31, 0) == 0,
                 $urandom_range(31, 0) == 0);
        end
        repeat (10) step(0, 0, 1, 0, 0, 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
